tag_mem_seq: RTL and testbench

//  Parametrised successor to the tag memory access path: sequences precharge/sense/write timing on the tag SRAM macro.

---
 rtl/tag_mem_pkg.sv | 25 ++
 rtl/tag_mem_piso.sv | 64 ++++++
 rtl/tag_mem_seq.sv | 218 +++++++++++++++++++++
 tb/tb_tag_mem_seq.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tag_mem_pkg.sv
// Shared encodings and default timing for the tag SRAM access sequencer.
// State codes are plain localparams so netlists and older tooling see stable values.
package tag_mem_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRECH = 3'd1;
  localparam logic [2:0] ST_SENSE = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_WRITE = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ADDR_W    = 6;
  localparam int DEF_SEL_W     = 3;
  localparam int DEF_PC_CYC    = 2;
  localparam int DEF_SENSE_CYC = 2;
  localparam int DEF_WR_CYC    = 3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tag_mem_piso.sv
// Parallel-in/serial-out register for one SRAM word: loads a word, shifts it out MSB first,
// and flags the final bit so the sequencer knows when the word has been fully consumed.
module tag_mem_piso #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              shift_en,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              last_bit
);

  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;

  assign last_bit  = valid_q && (cnt_q == CNT_W'(DATA_W - 1));
  assign bit_out   = shreg_q[DATA_W-1];
  assign bit_valid = valid_q;

  always_comb begin
    // NOTE: every _d signal gets a default first so no path can infer a latch.
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (load) begin
      shreg_d = load_data;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (shift_en && valid_q) begin
      shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
      if (last_bit) begin
        cnt_d   = '0;
        valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: rtl/tag_mem_seq.sv
// Tag SRAM access sequencer: precharge/sense/write timing on the macro pins, multi-word reads
// streamed bit-serially to the backscatter path, single-word writes. All outputs registered.
module tag_mem_seq
  import tag_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int SEL_W     = DEF_SEL_W,
  parameter int PC_CYC    = DEF_PC_CYC,
  parameter int SENSE_CYC = DEF_SENSE_CYC,
  parameter int WR_CYC    = DEF_WR_CYC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [SEL_W-1:0]  req_bank,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [7:0]        req_words,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              abort,
  input  logic              bit_clk_en,
  output logic              bit_out,
  output logic              bit_valid,
  input  logic [DATA_W-1:0] mem_read_in,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              PC_B,
  output logic              WE,
  output logic              SE,
  output logic [ADDR_W-1:0] mem_address,
  output logic [SEL_W-1:0]  mem_sel,
  output logic              busy,
  output logic              done,
  output logic              addr_wrap
);

  localparam int CNT_W = $clog2(max3(PC_CYC, SENSE_CYC, WR_CYC) + 1);

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  bank_q, bank_d;
  logic [7:0]        words_q, words_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              is_write_q, is_write_d;
  logic              wrap_q, wrap_d;

  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pc_b_q, pc_b_d;
  logic              we_q, we_d;
  logic              se_q, se_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [SEL_W-1:0]  mem_sel_q, mem_sel_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;

  logic accept, piso_load, piso_clear, piso_shift, piso_last, active_d;

  assign accept     = req_valid && req_ready_q && !abort;
  assign piso_clear = abort && (state_q != ST_IDLE);
  assign piso_shift = (state_q == ST_SHIFT) && bit_clk_en && !abort;

  tag_mem_piso #(.DATA_W(DATA_W)) u_piso (
    .clk       (clk),
    .reset     (reset),
    .clear     (piso_clear),
    .load      (piso_load),
    .load_data (mem_read_in),
    .shift_en  (piso_shift),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .last_bit  (piso_last)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    bank_d     = bank_q;
    words_d    = words_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    wrap_d     = wrap_q;
    piso_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d     = req_addr;
          bank_d     = req_bank;
          words_d    = req_words;
          wdata_d    = req_wdata;
          is_write_d = req_write;
          wrap_d     = 1'b0;
          cnt_d      = CNT_W'(PC_CYC - 1);
          state_d    = (!req_write && req_words == 8'd0) ? ST_DONE : ST_PRECH;
        end
      end
      ST_PRECH: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (is_write_q) begin
          // Extra leading cycle gives mem_data_out setup before WE rises.
          cnt_d   = CNT_W'(WR_CYC);
          state_d = ST_WRITE;
        end else begin
          cnt_d   = CNT_W'(SENSE_CYC - 1);
          state_d = ST_SENSE;
        end
      end
      ST_SENSE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          piso_load = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_clk_en && piso_last) begin
          if (words_q == 8'd1) begin
            state_d = ST_DONE;
          end else begin
            words_d = words_q - 8'd1;
            addr_d  = addr_q + 1'b1;
            if (addr_q == '1) wrap_d = 1'b1;
            cnt_d   = CNT_W'(PC_CYC - 1);
            state_d = ST_PRECH;
          end
        end
      end
      ST_WRITE: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && state_q != ST_IDLE) begin
      state_d   = ST_IDLE;
      cnt_d     = '0;
      addr_d    = addr_q;
      words_d   = words_q;
      wrap_d    = wrap_q;
      piso_load = 1'b0;
    end
  end

  // Pin values are derived from the next state so they change in step with it.
  always_comb begin
    active_d      = (state_d == ST_PRECH) || (state_d == ST_SENSE) ||
                    (state_d == ST_SHIFT) || (state_d == ST_WRITE);
    req_ready_d   = (state_d == ST_IDLE);
    busy_d        = (state_d != ST_IDLE);
    done_d        = (state_d == ST_DONE);
    pc_b_d        = (state_d != ST_PRECH);
    se_d          = (state_d == ST_SENSE);
    we_d          = (state_d == ST_WRITE) && (cnt_d != CNT_W'(WR_CYC));
    mem_data_d    = (state_d == ST_WRITE) ? wdata_d : '0;
    mem_address_d = active_d ? addr_d : '0;
    mem_sel_d     = active_d ? bank_d : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      addr_q        <= '0;
      bank_q        <= '0;
      words_q       <= '0;
      wdata_q       <= '0;
      is_write_q    <= 1'b0;
      wrap_q        <= 1'b0;
      req_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pc_b_q        <= 1'b1;
      we_q          <= 1'b0;
      se_q          <= 1'b0;
      mem_address_q <= '0;
      mem_sel_q     <= '0;
      mem_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      addr_q        <= addr_d;
      bank_q        <= bank_d;
      words_q       <= words_d;
      wdata_q       <= wdata_d;
      is_write_q    <= is_write_d;
      wrap_q        <= wrap_d;
      req_ready_q   <= req_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pc_b_q        <= pc_b_d;
      we_q          <= we_d;
      se_q          <= se_d;
      mem_address_q <= mem_address_d;
      mem_sel_q     <= mem_sel_d;
      mem_data_q    <= mem_data_d;
    end
  end

  assign req_ready    = req_ready_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign addr_wrap    = wrap_q;
  assign PC_B         = pc_b_q;
  assign WE           = we_q;
  assign SE           = se_q;
  assign mem_address  = mem_address_q;
  assign mem_sel      = mem_sel_q;
  assign mem_data_out = mem_data_q;

endmodule

// File: tb/tb_tag_mem_seq.sv
// Directed bench for tag_mem_seq: table of read/write transactions against a small SRAM model,
// plus hand-written abort and reset sequences.
module tb_tag_mem_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_bank;
  logic [5:0]  req_addr;
  logic [7:0]  req_words;
  logic [15:0] req_wdata;
  logic        abort, bit_clk_en, bit_out, bit_valid;
  logic [15:0] mem_read_in, mem_data_out;
  logic        PC_B, WE, SE;
  logic [5:0]  mem_address;
  logic [2:0]  mem_sel;
  logic        busy, done, addr_wrap;

  int n_checks = 0;
  int n_fail   = 0;
  int viol     = 0;

  always #5 clk = ~clk;

  tag_mem_seq dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_bank(req_bank), .req_addr(req_addr),
    .req_words(req_words), .req_wdata(req_wdata), .abort(abort),
    .bit_clk_en(bit_clk_en), .bit_out(bit_out), .bit_valid(bit_valid),
    .mem_read_in(mem_read_in), .mem_data_out(mem_data_out), .PC_B(PC_B),
    .WE(WE), .SE(SE), .mem_address(mem_address), .mem_sel(mem_sel),
    .busy(busy), .done(done), .addr_wrap(addr_wrap)
  );

  // SRAM model: fixed contents plus anything written; data only driven while SE is high.
  bit          written [8][64];
  logic [15:0] wmem    [8][64];

  function automatic logic [15:0] preset(input logic [2:0] sel, input logic [5:0] a);
    case ({sel, a})
      {3'd1, 6'd5}:  return 16'hA5C3;
      {3'd1, 6'd6}:  return 16'h0F0F;
      {3'd3, 6'd63}: return 16'hDEAD;
      {3'd3, 6'd0}:  return 16'hBEEF;
      {3'd3, 6'd1}:  return 16'hCAFE;
      default:       return {sel, a, 7'h55};
    endcase
  endfunction

  always_comb begin
    mem_read_in = 16'h0;
    if (SE) mem_read_in = written[mem_sel][mem_address] ? wmem[mem_sel][mem_address]
                                                        : preset(mem_sel, mem_address);
  end

  always @(posedge clk) begin
    if (WE) begin
      written[mem_sel][mem_address] <= 1'b1;
      wmem[mem_sel][mem_address]    <= mem_data_out;
    end
  end

  always @(negedge clk) begin
    if (WE && (SE || !PC_B)) viol++;
  end

  typedef struct {
    logic        wr;
    logic [2:0]  bank;
    logic [5:0]  addr;
    logic [7:0]  words;
    logic [15:0] wdata;
    logic        gaps;
    int          exp_done;
    int          exp_first_valid;
    int          exp_pcb;
    int          exp_se;
    int          exp_we;
    logic        exp_wrap;
    logic [47:0] exp_stream;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic wr, input logic [2:0] bank, input logic [5:0] addr,
                              input logic [7:0] words, input logic [15:0] wdata, input logic gaps,
                              input int dn, input int fv, input int pcb, input int se, input int we,
                              input logic wrap, input logic [47:0] stream);
    vec_t v;
    v.wr = wr; v.bank = bank; v.addr = addr; v.words = words; v.wdata = wdata; v.gaps = gaps;
    v.exp_done = dn; v.exp_first_valid = fv; v.exp_pcb = pcb; v.exp_se = se; v.exp_we = we;
    v.exp_wrap = wrap; v.exp_stream = stream;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    if (!req_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got req_ready=0 expected 1");
    end
  endtask

  task automatic drive_req(input logic wr, input logic [2:0] bank, input logic [5:0] addr,
                           input logic [7:0] words, input logic [15:0] wdata);
    req_valid = 1'b1; req_write = wr; req_bank = bank;
    req_addr = addr; req_words = words; req_wdata = wdata;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pcb"},   PC_B, 1'b1);
    check({tag, "_we"},    WE, 1'b0);
    check({tag, "_se"},    SE, 1'b0);
    check({tag, "_addr"},  mem_address, 6'd0);
    check({tag, "_sel"},   mem_sel, 3'd0);
    check({tag, "_wdata"}, mem_data_out, 16'd0);
    check({tag, "_bout"},  bit_out, 1'b0);
    check({tag, "_bval"},  bit_valid, 1'b0);
    check({tag, "_busy"},  busy, 1'b0);
    check({tag, "_done"},  done, 1'b0);
    check({tag, "_wrap"},  addr_wrap, 1'b0);
    check({tag, "_ready"}, req_ready, 1'b0);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          cyc = 1;
    int          done_cyc = -1, first_valid = -1;
    int          pcb = 0, se = 0, we = 0, nbits = 0, nword = 0, addr_bad = 0, wdata_bad = 0;
    logic [47:0] got = '0;
    logic        prev_low = 1'b0, wrap_at_done = 1'b0;
    bit          fin = 1'b0;
    string       t = $sformatf("v%0d", idx);

    wait_ready();
    drive_req(v.wr, v.bank, v.addr, v.words, v.wdata);
    tick();
    req_valid = 1'b0;
    while (!fin && cyc <= 400) begin
      if (!PC_B) begin
        pcb++;
        if (!prev_low) begin
          if (mem_address !== 6'(v.addr + nword) || mem_sel !== v.bank) addr_bad++;
          nword++;
        end
      end
      prev_low = !PC_B;
      if (SE) se++;
      if (WE) begin
        we++;
        if (mem_data_out !== v.wdata) wdata_bad++;
      end
      if (bit_valid && first_valid < 0) first_valid = cyc;
      bit_clk_en = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bit_valid && bit_clk_en) begin
        got = {got[46:0], bit_out};
        nbits++;
      end
      if (done) begin
        done_cyc = cyc;
        wrap_at_done = addr_wrap;
        fin = 1'b1;
      end else begin
        tick();
        cyc++;
      end
    end
    bit_clk_en = 1'b0;
    if (!fin) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no done expected done", t);
    end
    if (v.exp_done >= 0) check({t, "_done_cyc"}, done_cyc, v.exp_done);
    check({t, "_first_valid"}, first_valid, v.exp_first_valid);
    check({t, "_pcb_cycles"}, pcb, v.exp_pcb);
    check({t, "_se_cycles"}, se, v.exp_se);
    check({t, "_we_cycles"}, we, v.exp_we);
    check({t, "_nbits"}, nbits, v.wr ? 0 : int'(v.words) * 16);
    check({t, "_stream"}, got, v.exp_stream);
    check({t, "_addr_seq"}, addr_bad, 0);
    check({t, "_wdata"}, wdata_bad, 0);
    check({t, "_wrap_at_done"}, wrap_at_done, v.exp_wrap);
    tick();
    check({t, "_done_pulse"}, done, 1'b0);
    check({t, "_busy_after"}, busy, 1'b0);
    check({t, "_ready_after"}, req_ready, 1'b1);
    check({t, "_wrap_sticky"}, addr_wrap, v.exp_wrap);
  endtask

  initial begin
    logic [4:0] got5;
    int         nb;
    int         done_seen;

    vecs[0] = mk(0, 3'd1, 6'd5,  8'd2, 16'h0,    0, 41,  5, 4, 4, 0, 0, 48'h0000_A5C3_0F0F);
    vecs[1] = mk(1, 3'd2, 6'd9,  8'd0, 16'h1234, 0,  7, -1, 2, 0, 3, 0, 48'h0);
    vecs[2] = mk(0, 3'd2, 6'd9,  8'd1, 16'h0,    0, 21,  5, 2, 2, 0, 0, 48'h0000_0000_1234);
    vecs[3] = mk(0, 3'd3, 6'd63, 8'd3, 16'h0,    0, 61,  5, 6, 6, 0, 1, 48'hDEAD_BEEF_CAFE);
    vecs[4] = mk(0, 3'd1, 6'd5,  8'd0, 16'h0,    0,  1, -1, 0, 0, 0, 0, 48'h0);
    vecs[5] = mk(0, 3'd1, 6'd5,  8'd2, 16'h0,    1, -1,  5, 4, 4, 0, 0, 48'h0000_A5C3_0F0F);

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_bank = '0; req_addr = '0;
    req_words = '0; req_wdata = '0; abort = 1'b0; bit_clk_en = 1'b0;
    repeat (3) tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check("rst_release_ready", req_ready, 1'b1);

    // Abort in the same cycle as the handshake drops the request.
    drive_req(0, 3'd1, 6'd5, 8'd2, 16'h0);
    abort = 1'b1;
    tick();
    req_valid = 1'b0; abort = 1'b0;
    check("abort_accept_busy", busy, 1'b0);
    check("abort_accept_pcb", PC_B, 1'b1);
    check("abort_accept_ready", req_ready, 1'b1);

    // Abort mid-SHIFT after five consumed bits.
    wait_ready();
    drive_req(0, 3'd1, 6'd5, 8'd2, 16'h0);
    tick();
    req_valid = 1'b0;
    bit_clk_en = 1'b1;
    nb = 0; got5 = '0;
    for (int c = 0; c < 50 && nb < 5; c++) begin
      if (bit_valid) begin
        got5 = {got5[3:0], bit_out};
        nb++;
      end
      tick();
    end
    check("abort_shift_bits", got5, 5'b10100);
    check("abort_shift_valid_before", bit_valid, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0; bit_clk_en = 1'b0;
    check("abort_shift_bval", bit_valid, 1'b0);
    check("abort_shift_pcb", PC_B, 1'b1);
    check("abort_shift_we", WE, 1'b0);
    check("abort_shift_se", SE, 1'b0);
    check("abort_shift_busy", busy, 1'b0);
    check("abort_shift_ready", req_ready, 1'b1);
    done_seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (done) done_seen++;
      tick();
    end
    check("abort_shift_no_done", done_seen, 0);

    // Synchronous reset while sensing.
    wait_ready();
    drive_req(0, 3'd1, 6'd5, 8'd1, 16'h0);
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("rst_sense_se_before", SE, 1'b1);
    reset = 1'b1;
    tick();
    check_reset_vals("rst_sense");
    reset = 1'b0;
    tick();
    check("rst_sense_ready", req_ready, 1'b1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    check("we_overlap", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
